fft_sequencer: RTL and testbench
================================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter N_LOG2, default 3, log2 of FFT points N (N=8).
REQ-002 SHALL have parameter BF_LAT, default 2, butterfly-unit latency in cycles from bf_valid to its result.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a transform, sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  one input sample is present this cycle, sampled only in LOAD.
REQ-007 SHALL have port switch  input  1  asynchronous user step button that advances the output index.
REQ-008 SHALL have port load_en  output  1  write the current sample to the sample RAM at load_addr.
REQ-009 SHALL have port load_addr  output  N_LOG2  bit-reversed load address.
REQ-010 SHALL have port bf_valid  output  1  issue one butterfly this cycle.
REQ-011 SHALL have ports addr_a, addr_b  output  N_LOG2 each  butterfly operand addresses.
REQ-012 SHALL have port tw_idx  output  N_LOG2-1  twiddle ROM index.
REQ-013 SHALL have port stage  output  ceil(log2(N_LOG2))  current stage number.
REQ-014 SHALL have ports wb_en, wb_addr_a, wb_addr_b  output  1/N_LOG2/N_LOG2  butterfly write-back strobe and addresses.
REQ-015 SHALL have ports out_addr  output  N_LOG2 and out_valid  output  1  result-RAM read index and its qualifier.
REQ-016 SHALL have ports busy  output  1 (state is not IDLE) and done  output  1 (one-cycle pulse).

Function
REQ-017 SHALL implement the states IDLE, LOAD, COMPUTE, WAIT and OUTPUT.
REQ-018 IDLE with start=1 SHALL go to LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-019 In LOAD, each cycle with in_valid=1 SHALL assert load_en combinationally, with load_addr = bitrev(load count), and increment the count.
REQ-020 In LOAD, cycles with in_valid=0 SHALL hold the count and keep load_en=0.
REQ-021 After the Nth accepted sample, the FSM SHALL enter COMPUTE with stage=0 and butterfly index j=0.
REQ-022 In COMPUTE, the FSM SHALL issue one butterfly per cycle with bf_valid=1 for j=0..N/2-1, using the radix-2 DIT addressing below.
REQ-023 Addressing: half=2^stage, pos=j mod half, addr_a=(j>>stage)*2*half+pos, addr_b=addr_a+half, tw_idx=pos<<(N_LOG2-1-stage).
REQ-024 After j=N/2-1, the FSM SHALL enter WAIT for exactly BF_LAT cycles with bf_valid=0, to avoid a read-after-write hazard between stages.
REQ-025 At the end of WAIT, if stage<N_LOG2-1, the FSM SHALL increment stage, clear j and return to COMPUTE.
REQ-026 At the end of WAIT on the last stage, the FSM SHALL enter OUTPUT and pulse done for one cycle.
REQ-027 wb_en, wb_addr_a and wb_addr_b SHALL equal bf_valid, addr_a and addr_b delayed by exactly BF_LAT cycles through a shift pipeline.
REQ-028 Compute phase length SHALL be N_LOG2*(N/2+BF_LAT) cycles (18 for the defaults).
REQ-029 switch SHALL pass through a 2-flop synchronizer followed by rising-edge detection; each detected edge is one step, 3 cycles after the pin edge.
REQ-030 In OUTPUT, out_valid SHALL be 1 and out_addr SHALL start at 0.
REQ-031 In OUTPUT, each step with out_addr<N-1 SHALL increment out_addr.
REQ-032 In OUTPUT, a step at out_addr=N-1 SHALL wrap out_addr to 0 and return the FSM to IDLE.
REQ-033 Steps outside OUTPUT SHALL be ignored.
REQ-034 A new start SHALL be accepted only after the return to IDLE.

Reset
REQ-035 reset=0 SHALL immediately, asynchronously, force IDLE from any state, including mid-LOAD and mid-COMPUTE.
REQ-036 While reset=0, all counters, stage and out_addr SHALL be 0.
REQ-037 While reset=0, all outputs SHALL be 0, the delay pipeline SHALL be cleared (no stale wb_en) and the synchronizer flops SHALL be 0.
REQ-038 After reset release, the FSM SHALL stay in IDLE until start is seen.

Verification
REQ-039 Start followed by 8 back-to-back in_valid cycles -> load_addr sequence 0,4,2,6,1,5,3,7, then COMPUTE.
REQ-040 Full compute -> (a,b,tw) pairs: stage 0 (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage 1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage 2 (0,4,0)(1,5,1)(2,6,2)(3,7,3); done pulses 18 cycles after COMPUTE entry.
REQ-041 Each wb_en pulse -> matches its bf_valid pulse 2 cycles earlier with identical addresses; no bf_valid in the 2 WAIT cycles.
REQ-042 switch toggled every 22 ns (10 ns clk) in OUTPUT -> out_addr 0..7, wrapping to 0 and IDLE on the 8th rising edge; falling edges cause no step.
REQ-043 reset=0 asserted at compute cycle 7 -> busy=0 and all outputs 0 with no clock edge needed; a fresh start then repeats the REQ-039 sequence.
REQ-044 in_valid gaps during LOAD and start pulses during COMPUTE -> count held and start ignored.

Source files
------------

// File: rtl/fft_sequencer.sv
// Address and control sequencer for an in-place radix-2 DIT FFT: bit-reversed load,
// per-stage butterfly issue with a latency-matched write-back pipeline, and stepped readout.
module fft_sequencer #(
    parameter int N_LOG2 = 3,
    parameter int BF_LAT = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          in_valid,
    input  logic                                          switch,
    output logic                                          load_en,
    output logic [N_LOG2-1:0]                             load_addr,
    output logic                                          bf_valid,
    output logic [N_LOG2-1:0]                             addr_a,
    output logic [N_LOG2-1:0]                             addr_b,
    output logic [N_LOG2-2:0]                             tw_idx,
    output logic [((N_LOG2 > 1) ? $clog2(N_LOG2) : 1)-1:0] stage,
    output logic                                          wb_en,
    output logic [N_LOG2-1:0]                             wb_addr_a,
    output logic [N_LOG2-1:0]                             wb_addr_b,
    output logic [N_LOG2-1:0]                             out_addr,
    output logic                                          out_valid,
    output logic                                          busy,
    output logic                                          done
);

    localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int JW = N_LOG2 - 1;
    localparam int WW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t             r_state;
    logic [N_LOG2-1:0]  r_loadCnt;
    logic [N_LOG2-1:0]  r_outAddr;
    logic [JW-1:0]      r_j;
    logic [SW-1:0]      r_stage;
    logic [WW-1:0]      r_waitCnt;
    logic               r_done;
    logic               r_sw1;
    logic               r_sw2;
    logic               r_sw3;
    logic               r_step;
    logic [BF_LAT-1:0]  r_pipeValid;
    logic [N_LOG2-1:0]  r_pipeA [BF_LAT];
    logic [N_LOG2-1:0]  r_pipeB [BF_LAT];

    logic               w_compute;
    logic [JW-1:0]      w_mask;
    logic [JW-1:0]      w_pos;
    logic [N_LOG2-1:0]  w_half;
    logic [N_LOG2-1:0]  w_addrA;
    logic [N_LOG2-1:0]  w_loadRev;

    // Button path: two flops against metastability, a third for edge detect, a registered step pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw1  <= 1'b0;
            r_sw2  <= 1'b0;
            r_sw3  <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_sw1  <= switch;
            r_sw2  <= r_sw1;
            r_sw3  <= r_sw2;
            r_step <= r_sw2 & ~r_sw3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_loadCnt <= '0;
            r_outAddr <= '0;
            r_j       <= '0;
            r_stage   <= '0;
            r_waitCnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_loadCnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_loadCnt <= r_loadCnt + 1'b1;
                        if (r_loadCnt == '1) begin
                            r_state <= S_COMPUTE;
                            r_stage <= '0;
                            r_j     <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_j <= r_j + 1'b1;
                    if (r_j == '1) begin
                        r_state   <= S_WAIT;
                        r_waitCnt <= '0;
                    end
                end
                // Hold off the next stage until the last write-back of this one has landed.
                S_WAIT: begin
                    if (r_waitCnt == WW'(BF_LAT - 1)) begin
                        r_j <= '0;
                        if (r_stage == SW'(N_LOG2 - 1)) begin
                            r_state   <= S_OUTPUT;
                            r_stage   <= '0;
                            r_outAddr <= '0;
                            r_done    <= 1'b1;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_state <= S_COMPUTE;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (r_step) begin
                        if (r_outAddr == '1) begin
                            r_outAddr <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_outAddr <= r_outAddr + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_LOG2; g++) begin : g_rev
        assign w_loadRev[g] = r_loadCnt[N_LOG2-1-g];
    end

    // Low stage bits of j select the position inside a group, the rest select the group.
    always_comb begin
        w_compute = (r_state == S_COMPUTE);
        w_mask    = ~({JW{1'b1}} << r_stage);
        w_pos     = r_j & w_mask;
        w_half    = N_LOG2'(1) << r_stage;
        w_addrA   = {r_j & ~w_mask, 1'b0} + {1'b0, w_pos};
    end

    assign load_en   = (r_state == S_LOAD) && in_valid;
    assign load_addr = w_loadRev;
    assign bf_valid  = w_compute;
    assign addr_a    = w_compute ? w_addrA : '0;
    assign addr_b    = w_compute ? (w_addrA + w_half) : '0;
    assign tw_idx    = w_compute ? (w_pos << (SW'(N_LOG2 - 1) - r_stage)) : '0;
    assign stage     = r_stage;
    assign out_addr  = r_outAddr;
    assign out_valid = (r_state == S_OUTPUT);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipeValid <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                r_pipeA[i] <= '0;
                r_pipeB[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= bf_valid;
            r_pipeA[0]     <= addr_a;
            r_pipeB[0]     <= addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeA[i]     <= r_pipeA[i-1];
                r_pipeB[i]     <= r_pipeB[i-1];
            end
        end
    end

    assign wb_en     = r_pipeValid[BF_LAT-1];
    assign wb_addr_a = r_pipeA[BF_LAT-1];
    assign wb_addr_b = r_pipeB[BF_LAT-1];

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: load order, butterfly addressing, write-back timing,
// output stepping through the button synchronizer, and asynchronous reset mid-transform.
module tb_fft_sequencer;

    localparam int N_LOG2 = 3;
    localparam int BF_LAT = 2;
    localparam int LOAD_TAB [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    localparam int BF_A_TAB [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int BF_B_TAB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int BF_T_TAB [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    localparam int BF_S_TAB [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic              switch   = 1'b0;
    logic              load_en;
    logic [N_LOG2-1:0] load_addr;
    logic              bf_valid;
    logic [N_LOG2-1:0] addr_a;
    logic [N_LOG2-1:0] addr_b;
    logic [N_LOG2-2:0] tw_idx;
    logic [1:0]        stage;
    logic              wb_en;
    logic [N_LOG2-1:0] wb_addr_a;
    logic [N_LOG2-1:0] wb_addr_b;
    logic [N_LOG2-1:0] out_addr;
    logic              out_valid;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int loadQ [$];
    int bfAQ [$];
    int bfBQ [$];
    int bfTQ [$];
    int bfSQ [$];
    int wbCQ [$];
    int wbAQ [$];
    int wbBQ [$];
    int ea;
    int eb;

    fft_sequencer #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .switch    (switch),
        .load_en   (load_en),
        .load_addr (load_addr),
        .bf_valid  (bf_valid),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_idx    (tw_idx),
        .stage     (stage),
        .wb_en     (wb_en),
        .wb_addr_a (wb_addr_a),
        .wb_addr_b (wb_addr_b),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every strobe must match the next expected entry in order.
    always @(negedge clk) begin
        if (load_en) begin
            if (loadQ.size() == 0) checkOutput("load_extra", load_en, 0);
            else checkOutput("load_addr", load_addr, loadQ.pop_front());
        end
        if (bf_valid) begin
            if (bfAQ.size() == 0) begin
                checkOutput("bf_extra", bf_valid, 0);
            end else begin
                ea = bfAQ.pop_front();
                eb = bfBQ.pop_front();
                checkOutput("addr_a", addr_a, ea);
                checkOutput("addr_b", addr_b, eb);
                checkOutput("tw_idx", tw_idx, bfTQ.pop_front());
                checkOutput("stage", stage, bfSQ.pop_front());
                wbCQ.push_back(cyc + BF_LAT);
                wbAQ.push_back(ea);
                wbBQ.push_back(eb);
            end
        end
        if (wb_en) begin
            if (wbCQ.size() == 0) begin
                checkOutput("wb_extra", wb_en, 0);
            end else begin
                checkOutput("wb_cycle", cyc, wbCQ.pop_front());
                checkOutput("wb_addr_a", wb_addr_a, wbAQ.pop_front());
                checkOutput("wb_addr_b", wb_addr_b, wbBQ.pop_front());
            end
        end
    end

    task automatic pushExpected(input int nBf);
        for (int i = 0; i < 8; i++) loadQ.push_back(LOAD_TAB[i]);
        for (int i = 0; i < nBf; i++) begin
            bfAQ.push_back(BF_A_TAB[i]);
            bfBQ.push_back(BF_B_TAB[i]);
            bfTQ.push_back(BF_T_TAB[i]);
            bfSQ.push_back(BF_S_TAB[i]);
        end
    endtask

    // Start a transform and feed 8 samples, in_valid following the bit pattern (gaps allowed).
    task automatic applyStimulus(input logic [15:0] pattern);
        int accepted;
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_load", busy, 1);
        accepted = 0;
        k = 0;
        while (accepted < 8 && k < 40) begin
            in_valid = pattern[k % 16];
            tick();
            if (in_valid) accepted++;
            k++;
        end
        in_valid = 1'b0;
        checkOutput("load_count", loadQ.size(), 0);
        checkOutput("compute_entry", bf_valid, 1);
    endtask

    task automatic runCompute(input bit pulseStart);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            start = (pulseStart && (n == 3 || n == 9));
            tick();
            n++;
        end
        start = 1'b0;
        checkOutput("done_latency", n, 18);
        checkOutput("out_valid_entry", out_valid, 1);
        checkOutput("out_addr_entry", out_addr, 0);
        checkOutput("bf_all_issued", bfAQ.size(), 0);
        checkOutput("wb_all_seen", wbCQ.size(), 0);
        tick();
        checkOutput("done_pulse", done, 0);
    endtask

    task automatic stepOutput();
        for (int k = 0; k < 8; k++) begin
            switch = 1'b1;
            #22;
            switch = 1'b0;
            #22;
            if (k < 7) begin
                checkOutput("out_addr_step", out_addr, k + 1);
                checkOutput("out_valid_step", out_valid, 1);
            end else begin
                checkOutput("out_addr_wrap", out_addr, 0);
                checkOutput("idle_after_wrap", busy, 0);
                checkOutput("out_valid_wrap", out_valid, 0);
            end
        end
        switch = 1'b1;
        #22;
        switch = 1'b0;
        #22;
        checkOutput("idle_step_ignored", out_addr, 0);
        checkOutput("idle_step_busy", busy, 0);
        tick();
    endtask

    initial begin
        start    = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_load_en", load_en, 0);
        checkOutput("rst_bf_valid", bf_valid, 0);
        checkOutput("rst_wb_en", wb_en, 0);
        checkOutput("rst_stage", stage, 0);
        checkOutput("rst_out_addr", out_addr, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) tick();
        checkOutput("idle_hold", busy, 0);

        $display("[TB] run 1: back-to-back load, full transform");
        pushExpected(12);
        applyStimulus(16'hFFFF);
        runCompute(1'b0);
        stepOutput();

        $display("[TB] run 2: gapped load, start pulses, reset at compute cycle 7");
        pushExpected(5);
        applyStimulus(16'hB5A9);
        for (int k = 0; k < 7; k++) begin
            start = (k == 2);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_bf_valid", bf_valid, 0);
        checkOutput("abort_addr_a", addr_a, 0);
        checkOutput("abort_addr_b", addr_b, 0);
        checkOutput("abort_tw_idx", tw_idx, 0);
        checkOutput("abort_stage", stage, 0);
        checkOutput("abort_wb_en", wb_en, 0);
        checkOutput("abort_wb_addr_a", wb_addr_a, 0);
        checkOutput("abort_wb_addr_b", wb_addr_b, 0);
        checkOutput("abort_bf_issued", bfAQ.size(), 0);
        wbCQ.delete();
        wbAQ.delete();
        wbBQ.delete();
        #3;
        reset = 1'b1;
        repeat (4) tick();
        checkOutput("post_abort_idle", busy, 0);

        $display("[TB] run 3: fresh transform after abort");
        pushExpected(12);
        applyStimulus(16'hFFFF);
        runCompute(1'b1);
        stepOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
